// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM host-port arbiter.
// Burst FSM states and arbitration mode selectors.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA
   } arb_state_t;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection for the SDRAM arbiter.
// Round-robin from rr_ptr, or lowest index first.
module sdram_arb_pick
   import sdram_arb_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int MODE = MODE_RR,
   parameter int IW   = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  rr_ptr,
   output logic [IW-1:0]  win,
   output logic           valid
);

   // Scan requesters; first hit in the search order wins.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      if (MODE == MODE_FIXED) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
               win   = IW'(i);
               valid = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (!valid && req[(int'(rr_ptr) + k) % NCH]) begin
               win   = IW'((int'(rr_ptr) + k) % NCH);
               valid = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// N-channel burst arbiter in front of one SDRAM host port.
// One burst outstanding; data beats pass straight through.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int AW    = 18,
   parameter int DW    = 16,
   parameter int BURST = 16,
   parameter int MODE  = MODE_RR
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [NCH-1:0]    c_req,
   input  logic [NCH-1:0]    c_we,
   input  logic [NCH*AW-1:0] c_addr,
   input  logic [NCH*DW-1:0] c_wdata,
   output logic [NCH-1:0]    c_gnt,
   output logic [NCH-1:0]    c_wready,
   output logic [NCH-1:0]    c_rvalid,
   output logic [DW-1:0]     c_rdata,
   output logic [NCH-1:0]    c_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   input  logic              mem_gnt,
   output logic [DW-1:0]     mem_wdata,
   input  logic              mem_wready,
   input  logic              mem_rvalid,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int IW = $clog2(NCH);
   localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0] LAST = CW'(BURST - 1);

   arb_state_t       state, state_d;
   logic [IW-1:0]    idx, rr_ptr, win;
   logic             win_vld;
   logic             we_r;
   logic [AW-1:0]    addr_r;
   logic [CW-1:0]    cnt;
   logic             beat, last;

   sdram_arb_pick #(
      .NCH  (NCH),
      .MODE (MODE),
      .IW   (IW)
   ) u_pick (
      .req    (c_req),
      .rr_ptr (rr_ptr),
      .win    (win),
      .valid  (win_vld)
   );

   // Next state and per-channel strobes, gated by state and idx.
   always_comb begin
      state_d  = state;
      c_gnt    = '0;
      c_wready = '0;
      c_rvalid = '0;
      c_done   = '0;
      beat     = 1'b0;
      unique case (state)
         IDLE: begin
            if (win_vld) state_d = CMD;
         end
         CMD: begin
            if (mem_gnt) begin
               c_gnt[idx] = 1'b1;
               state_d    = we_r ? WDATA : RDATA;
            end
         end
         WDATA: begin
            c_wready[idx] = mem_wready;
            beat          = mem_wready;
         end
         RDATA: begin
            c_rvalid[idx] = mem_rvalid;
            beat          = mem_rvalid;
         end
         default: state_d = IDLE;
      endcase
      last = beat && (cnt == LAST);
      if (last) begin
         c_done[idx] = 1'b1;
         state_d     = IDLE;
      end
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_d;
   end

   // Capture the winning command at arbitration time.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx    <= '0;
         we_r   <= 1'b0;
         addr_r <= '0;
      end else if (state == IDLE && win_vld) begin
         idx    <= win;
         we_r   <= c_we[win];
         addr_r <= c_addr[win*AW +: AW];
      end
   end

   // Beat counter: cleared on command accept, advanced per beat.
   always_ff @(posedge Clk) begin
      if (Reset)                       cnt <= '0;
      else if (state == CMD && mem_gnt) cnt <= '0;
      else if (beat)                   cnt <= last ? '0 : cnt + 1'b1;
   end

   // Round-robin pointer moves past the channel that just finished.
   always_ff @(posedge Clk) begin
      if (Reset)     rr_ptr <= '0;
      else if (last) rr_ptr <= (idx == IW'(NCH - 1)) ? '0 : idx + 1'b1;
   end

   assign mem_req   = (state == CMD);
   assign mem_we    = we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = c_wdata[idx*DW +: DW];
   assign c_rdata   = mem_rdata;

endmodule
